// File: rtl/round_div_pkg.sv
// Shared types and sizing helpers for the sequential rounding divider.
// Holds the FSM state encoding and the iteration-counter width function.
package round_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach W+1, the index of the last of the W+2 iterations
  function automatic int cnt_w(input int w);
    return $clog2(w + 3);
  endfunction

endpackage

// File: rtl/round_div_seq.sv
// Sequential signed divider, round-to-nearest with ties away from zero.
// A restoring divider computes floor((2|x|+|y|)/(2|y|)), one bit per cycle.
module round_div_seq
  import round_div_pkg::*;
#(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         div_zero,
  output logic         ovf
);

  localparam int            CW   = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W + 1);

  state_e         state_r, state_s;
  logic [CW-1:0]  cnt_r;
  logic [W:0]     rem_r;
  logic [W:0]     den_r;
  logic [W+1:0]   nq_r;
  logic           neg_r;
  logic           in_ready_r, out_valid_r, div_zero_r, ovf_r;
  logic [W-1:0]   result_r;

  logic           in_ready_s, out_valid_s, div_zero_s, ovf_nx_s;
  logic [W-1:0]   result_s;

  logic [W:0]     sx_s, sy_s, ax_s, ay_s, den_s;
  logic [W+1:0]   num_s;
  logic           y_zero_s, fire_s, ofire_s, last_s;

  logic [W+1:0]   rem_sh_s, rem_nx_s, q_nx_s;
  logic           ge_s, ovf_s;
  logic [W-1:0]   mag_s, signed_s, fmt_s;

  // Magnitudes carry one extra bit so that |-2^(W-1)| is exact
  assign sx_s     = {x[W-1], x};
  assign sy_s     = {y[W-1], y};
  assign ax_s     = x[W-1] ? ((W+1)'(0) - sx_s) : sx_s;
  assign ay_s     = y[W-1] ? ((W+1)'(0) - sy_s) : sy_s;
  assign num_s    = {ax_s, 1'b0} + {1'b0, ay_s};
  assign den_s    = {ay_s[W-1:0], 1'b0};
  assign y_zero_s = (y == W'(0));

  assign fire_s   = in_valid & in_ready_r;
  assign ofire_s  = out_valid_r & out_ready;
  assign last_s   = (cnt_r == LAST);

  // nq_r shifts the numerator out of its MSB while quotient bits enter at the LSB
  assign rem_sh_s = {rem_r, nq_r[W+1]};
  assign ge_s     = (rem_sh_s >= {1'b0, den_r});
  assign rem_nx_s = ge_s ? (rem_sh_s - {1'b0, den_r}) : rem_sh_s;
  assign q_nx_s   = {nq_r[W:0], ge_s};

  // Only a positive magnitude of 2^(W-1) or more is unrepresentable
  assign ovf_s    = ~neg_r & (q_nx_s[W+1:W-1] != 3'b000);
  assign mag_s    = q_nx_s[W-1:0];
  assign signed_s = neg_r ? (W'(0) - mag_s) : mag_s;
  assign fmt_s    = (ovf_s && SAT) ? {1'b0, {(W-1){1'b1}}} : signed_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s = y_zero_s ? DONE : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (ofire_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered handshake and result outputs
  always_comb begin
    in_ready_s  = (state_s == IDLE);
    out_valid_s = out_valid_r;
    result_s    = result_r;
    div_zero_s  = div_zero_r;
    ovf_nx_s    = ovf_r;
    case (state_r)
      IDLE: begin
        if (fire_s && y_zero_s) begin
          out_valid_s = 1'b1;
          result_s    = W'(0);
          div_zero_s  = 1'b1;
          ovf_nx_s    = 1'b0;
        end else begin
          out_valid_s = 1'b0;
        end
      end
      CALC: begin
        if (last_s) begin
          out_valid_s = 1'b1;
          result_s    = fmt_s;
          div_zero_s  = 1'b0;
          ovf_nx_s    = ovf_s;
        end else begin
          out_valid_s = 1'b0;
        end
      end
      DONE: begin
        if (ofire_s) begin
          out_valid_s = 1'b0;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= W'(0);
      div_zero_r  <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      result_r    <= result_s;
      div_zero_r  <= div_zero_s;
      ovf_r       <= ovf_nx_s;
    end
  end

  // Divider datapath: operand capture on fire, one restoring step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
      rem_r <= (W+1)'(0);
      den_r <= (W+1)'(0);
      nq_r  <= (W+2)'(0);
      neg_r <= 1'b0;
    end else if (state_r == IDLE && fire_s) begin
      cnt_r <= CW'(0);
      rem_r <= (W+1)'(0);
      den_r <= den_s;
      nq_r  <= num_s;
      neg_r <= x[W-1] ^ y[W-1];
    end else if (state_r == CALC) begin
      cnt_r <= cnt_r + CW'(1);
      rem_r <= rem_nx_s[W:0];
      nq_r  <= q_nx_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign div_zero  = div_zero_r;
  assign ovf       = ovf_r;

endmodule

// File: doc/round_div_seq.md
ROUND_DIV_SEQ -- requirements
Module: round_div_seq

Interface
REQ-001 SHALL have parameter W, default 32: operand and quotient width in bits, legal range 4..64.
REQ-002 SHALL have parameter SAT, default 1: 1 = saturate quotient on overflow, 0 = wrap to W bits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: operands present.
REQ-006 SHALL have port in_ready  output  1: block can accept operands.
REQ-007 SHALL have port x  input  W: signed dividend.
REQ-008 SHALL have port y  input  W: signed divisor, runtime value.
REQ-009 SHALL have port out_valid  output  1: result present.
REQ-010 SHALL have port out_ready  input  1: consumer accepts result.
REQ-011 SHALL have port result  output  W: signed rounded quotient.
REQ-012 SHALL have port div_zero  output  1: y was 0 for this result.
REQ-013 SHALL have port ovf  output  1: true quotient not representable in W signed bits.

Function
REQ-014 SHALL compute result = sign(x)*sign(y) * floor((2|x| + |y|) / (2|y|)): round to nearest, ties away from zero.
REQ-015 SHALL form magnitudes in W+1 bits, numerator 2|x|+|y| in W+2 bits and denominator 2|y| in W+1 bits, so that |x| = 2^(W-1) is exact.
REQ-016 SHALL use a restoring divider that retires one quotient bit per cycle, W+2 iterations in total.
REQ-017 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-018 SHALL assert in_ready only in IDLE; an input fire is in_valid and in_ready high in the same cycle.
REQ-019 SHALL, on an input fire with y != 0, latch operands and go IDLE -> CALC.
REQ-020 SHALL leave CALC for DONE after exactly W+2 cycles, asserting out_valid on the cycle after the last iteration (fire cycle 0 gives out_valid at cycle W+3).
REQ-021 SHALL, on an input fire with y == 0, go IDLE -> DONE directly with result 0, div_zero 1 and ovf 0, asserting out_valid at cycle 1.
REQ-022 SHALL, when the signed result exceeds 2^(W-1)-1 (only x = -2^(W-1), y = -1), set ovf 1 and output 2^(W-1)-1 if SAT=1, else the wrapped value -2^(W-1).
REQ-023 SHALL hold result, div_zero, ovf and out_valid stable in DONE until out_ready is high.
REQ-024 SHALL, when out_valid and out_ready are both high, return DONE -> IDLE, asserting in_ready in the next cycle; no input is accepted in the same cycle as an output fire.
REQ-025 SHALL ignore in_valid and operand changes while in CALC or DONE.
REQ-026 SHALL produce result 0 with ovf 0 when |x| < |y|/2 (e.g. 4/9); the tie x/y = k+0.5 SHALL round to magnitude k+1.

Reset
REQ-027 SHALL, on rst_n low, immediately force state to IDLE and out_valid, result, div_zero and ovf to 0, aborting any division in progress without output.
REQ-028 SHALL hold in_ready at 0 while rst_n is low and assert it in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state enum and the iteration-count width function ($clog2(W+3)) in package round_div_pkg.
REQ-030 SHALL be a single module with no sub-modules: sign/magnitude, iteration datapath and output formatting live in round_div_seq.

Verification
REQ-031 SHALL cover W=32: x=104, y=9 -> result 12; x=100, y=9 -> 11; x=-104, y=9 -> -12, each with out_valid at cycle 35 after the fire.
REQ-032 SHALL cover ties: x=9, y=2 -> 5; x=-9, y=2 -> -5; x=9, y=-2 -> -5; x=-9, y=-2 -> 5.
REQ-033 SHALL cover divide-by-zero: x=5, y=0 -> result 0, div_zero 1, out_valid at cycle 1.
REQ-034 SHALL cover overflow: x=0x80000000, y=-1 -> 0x7FFFFFFF, ovf 1 with SAT=1; 0x80000000, ovf 1 with SAT=0.
REQ-035 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready 0, a new in_valid ignored; then out_ready 1 -> in_ready 1 on the next cycle.
REQ-036 SHALL cover reset mid-CALC: rst_n low at cycle 10 of a division -> out_valid stays 0, state IDLE; a following 7/2 -> 4 completes normally.
